// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data memory store buffer: byte-enable
// codes, drain FSM states, entry field widths and the store lane aligner.
package dm_pkg;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } drain_state_e;

  // Replicate the raw rt value onto every lane it could be written to, so the
  // byte enables alone pick the bytes that land in the RAM word.
  function automatic logic [DATA_W-1:0] align_data(input logic [BE_W-1:0]   be_v,
                                                   input logic [DATA_W-1:0] data_v);
    logic [DATA_W-1:0] res_v;
    case (be_v)
      BE_WORD:         res_v = data_v;
      BE_HLO, BE_HHI:  res_v = {data_v[15:0], data_v[15:0]};
      default:         res_v = {4{data_v[7:0]}};
    endcase
    return res_v;
  endfunction

endpackage

// File: rtl/dm_sbuf_fifo.sv
// Circular store-buffer FIFO. Every slot and its valid bit is exported so the
// load path can forward pending bytes; the read pointer gives the age order.
module dm_sbuf_fifo
  import dm_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 46,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ENTRY_W-1:0]       push_entry,
  output logic [ENTRY_W-1:0]       head_entry,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic [PTR_W-1:0]         rd_ptr,
  output logic [DEPTH*ENTRY_W-1:0] entries_flat,
  output logic [DEPTH-1:0]         valid
);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [DEPTH-1:0]   valid_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               full_s;
  logic               push_ok_s;
  logic               pop_ok_s;

  assign full_s    = (count_r == CNT_W'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Slot storage, valid bits, pointers and occupancy; the push is written after
  // the pop so a full push+pop on the shared slot leaves it valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ENTRY_W{1'b0}};
      end
      valid_r  <= {DEPTH{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (pop_ok_s) begin
        valid_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
      end
      if (push_ok_s) begin
        mem_r[wr_ptr_r]   <= push_entry;
        valid_r[wr_ptr_r] <= 1'b1;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_flat
    assign entries_flat[k*ENTRY_W +: ENTRY_W] = mem_r[k];
  end

  assign head_entry = mem_r[rd_ptr_r];
  assign count      = count_r;
  assign full       = full_s;
  assign rd_ptr     = rd_ptr_r;
  assign valid      = valid_r;

endmodule

// File: rtl/dm_store_buffer.sv
// MEM-stage data memory: stores are lane-aligned and queued, a slow FSM drains
// the head entry into the word RAM, and loads see the RAM word overlaid with
// every pending byte for that word (youngest store wins per byte).
module dm_store_buffer
  import dm_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int WR_LAT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] ao,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        empty
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int LAT_W    = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam int ENTRY_W  = ADDR_W + BE_W + DATA_W;
  localparam int BE_LSB   = DATA_W;
  localparam int ADDR_LSB = DATA_W + BE_W;
  localparam int WORDS    = 1 << ADDR_W;

  logic [ADDR_W-1:0]        word_addr_s;
  logic                     unused_s;
  logic                     store_req_s;
  logic                     push_s;
  logic                     commit_s;
  logic [ENTRY_W-1:0]       push_entry_s;
  logic [ENTRY_W-1:0]       head_entry_s;
  logic [CNT_W-1:0]         count_s;
  logic                     full_s;
  logic [PTR_W-1:0]         rd_ptr_s;
  logic [DEPTH*ENTRY_W-1:0] entries_flat_s;
  logic [DEPTH-1:0]         valid_s;
  logic [ENTRY_W-1:0]       age_entry_s [DEPTH];
  logic                     age_valid_s [DEPTH];
  logic [ADDR_W-1:0]        head_addr_s;
  logic [BE_W-1:0]          head_be_s;
  logic [DATA_W-1:0]        head_data_s;
  logic [DATA_W-1:0]        rdata_s;
  logic [DATA_W-1:0]        ram_r [WORDS];
  drain_state_e             state_r;
  drain_state_e             state_nxt_s;
  logic [LAT_W-1:0]         cnt_r;
  logic [LAT_W-1:0]         cnt_nxt_s;

  // The merge ignores re and only the word-select bits of ao matter.
  assign word_addr_s = ao[ADDR_W+1:2];
  assign unused_s    = ^{re, ao[31:ADDR_W+2], ao[1:0]};

  // be==0000 is a no-op store: it neither enqueues nor stalls.
  assign store_req_s  = we && (be != BE_NONE);
  assign push_s       = store_req_s && (!full_s || commit_s);
  assign stall        = store_req_s && full_s && !commit_s;
  assign empty        = (count_s == {CNT_W{1'b0}}) && (state_r == S_IDLE);
  assign push_entry_s = {word_addr_s, be, align_data(be, wdata)};

  dm_sbuf_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push_s),
    .pop          (commit_s),
    .push_entry   (push_entry_s),
    .head_entry   (head_entry_s),
    .count        (count_s),
    .full         (full_s),
    .rd_ptr       (rd_ptr_s),
    .entries_flat (entries_flat_s),
    .valid        (valid_s)
  );

  assign head_addr_s = head_entry_s[ADDR_LSB +: ADDR_W];
  assign head_be_s   = head_entry_s[BE_LSB +: BE_W];
  assign head_data_s = head_entry_s[DATA_W-1:0];

  // Re-index the physical slots oldest-first starting at the read pointer.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] slot_s;
    assign slot_s         = rd_ptr_s + PTR_W'(k);
    assign age_entry_s[k] = entries_flat_s[slot_s*ENTRY_W +: ENTRY_W];
    assign age_valid_s[k] = valid_s[slot_s];
  end

  // Drain FSM state and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {LAT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Drain FSM: wait WR_LAT cycles in WRITE, commit the head on the last one,
  // then spend one cycle back in IDLE before the next entry starts.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_s != {CNT_W{1'b0}}) begin
          state_nxt_s = S_WRITE;
          cnt_nxt_s   = LAT_W'(WR_LAT - 1);
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WRITE: begin
        if (cnt_r == {LAT_W{1'b0}}) begin
          commit_s    = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - LAT_W'(1);
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = {LAT_W{1'b0}};
      end
    endcase
  end

  // Word RAM: cleared on reset, written only by a head commit, byte-enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WORDS; w++) begin
        ram_r[w] <= {DATA_W{1'b0}};
      end
    end else if (commit_s) begin
      for (int b = 0; b < BE_W; b++) begin
        if (head_be_s[b]) begin
          ram_r[head_addr_s][8*b +: 8] <= head_data_s[8*b +: 8];
        end
      end
    end
  end

  // Load merge: start from the RAM word and overlay matching entries oldest to
  // youngest, so the last (youngest) matching byte is the one that survives.
  always_comb begin
    rdata_s = ram_r[word_addr_s];
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < BE_W; b++) begin
        rdata_s[8*b +: 8] = (age_valid_s[k] &&
                             (age_entry_s[k][ADDR_LSB +: ADDR_W] == word_addr_s) &&
                             age_entry_s[k][BE_LSB + b])
                            ? age_entry_s[k][8*b +: 8]
                            : rdata_s[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_s;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Self-checking bench for dm_store_buffer: a table of cycle vectors with fixed
// expectations, hand-written reset/stall sequences, and a byte-level program-
// order memory model feeding a load scoreboard queue.
module tb_dm_store_buffer;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 4;
  localparam int WR_LAT = 3;

  logic        clk;
  logic        reset;
  logic        we;
  logic        re;
  logic [31:0] ao;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        empty;

  dm_store_buffer #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .re    (re),
    .ao    (ao),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata),
    .stall (stall),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] ao;
    logic [31:0] wd;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_stall;
    logic        exp_empty;
  } vec_t;

  vec_t        tbl [$];
  logic [31:0] exp_q [$];
  logic [31:0] model_mem [1 << ADDR_W];
  logic        stall_seen;
  logic        empty_seen;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  be_list [7] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] tb_align(input logic [3:0] b, input logic [31:0] d);
    case (b)
      4'b1111:          return d;
      4'b0011, 4'b1100: return {d[15:0], d[15:0]};
      default:          return {4{d[7:0]}};
    endcase
  endfunction

  task automatic model_clear();
    for (int w = 0; w < (1 << ADDR_W); w++) model_mem[w] = 32'h0;
  endtask

  task automatic model_store(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] al;
    al = tb_align(b, d);
    for (int k = 0; k < 4; k++) begin
      if (b[k]) model_mem[a[ADDR_W+1:2]][8*k +: 8] = al[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem[a[ADDR_W+1:2]];
  endfunction

  // One cycle: drive just after posedge, sample at negedge, retire the load.
  task automatic step(input logic s_we, input logic s_re, input logic [3:0] s_be,
                      input logic [31:0] s_ao, input logic [31:0] s_wd,
                      input logic chk, input logic [31:0] exp_rd, input string nm);
    we = s_we; re = s_re; be = s_be; ao = s_ao; wdata = s_wd;
    if (chk) exp_q.push_back(exp_rd);
    @(negedge clk);
    stall_seen = stall;
    empty_seen = empty;
    if (chk) check(nm, rdata, exp_q.pop_front());
    if (s_we && (s_be != 4'b0000) && !stall) model_store(s_ao, s_be, s_wd);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] a, input string nm);
    step(1'b0, 1'b1, 4'b0000, a, 32'h0, 1'b1, model_read(a), nm);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  // Upstream holds the store while stall is high.
  task automatic store_hold(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                            input string nm);
    int tries = 0;
    do begin
      step(1'b1, 1'b0, b, a, d, 1'b0, 32'h0, nm);
      tries++;
    end while (stall_seen && tries < 40);
    check({nm, "_accept"}, 32'(stall_seen), 32'd0);
  endtask

  task automatic wait_empty(input int budget, input string nm);
    int n = 0;
    do begin
      idle();
      n++;
    end while (!empty_seen && n < budget);
    check(nm, 32'(empty_seen), 32'd1);
  endtask

  task automatic add(input logic w, input logic [3:0] b, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] e, input logic s, input logic em);
    vec_t v;
    v = '{w, b, a, d, c, e, s, em};
    tbl.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int att;
    int acc;
    logic [31:0] a6;
    logic [3:0]  b6;
    int          j6;

    reset = 1'b0; we = 1'b0; re = 1'b0; be = 4'b0000; ao = 32'h0; wdata = 32'h0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b1;

    // Reset mid-WRITE with two entries queued.
    step(1'b1, 1'b0, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, "t1_st0");
    step(1'b1, 1'b0, 4'b1111, 32'h4, 32'hCAFEF00D, 1'b0, 32'h0, "t1_st1");
    idle();
    check("t1_busy_empty", 32'(empty_seen), 32'd0);
    #1;
    check("t1_fwd_before_reset", rdata, 32'hDEADBEEF);
    reset = 1'b0;
    #1;
    check("t1_empty_in_reset", 32'(empty), 32'd1);
    check("t1_rdata_in_reset", rdata, 32'h0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    repeat (WR_LAT + 2) idle();
    load(32'h0, "t1_load0");
    load(32'h4, "t1_load4");
    check("t1_empty_after", 32'(empty_seen), 32'd1);

    // Cycle table: forwarding, youngest-wins merge, halfword, be=0000 no-op.
    add(1, 4'b1111, 32'h10, 32'h11223344, 0, 32'h0,        0, 1);
    add(0, 4'b0000, 32'h10, 32'h0,        1, 32'h11223344, 0, 0);
    add(0, 4'b0000, 32'h10, 32'h0,        1, 32'h11223344, 0, 0);
    add(0, 4'b0000, 32'h10, 32'h0,        1, 32'h11223344, 0, 0);
    add(0, 4'b0000, 32'h10, 32'h0,        1, 32'h11223344, 0, 0);
    add(0, 4'b0000, 32'h10, 32'h0,        1, 32'h11223344, 0, 1);
    add(1, 4'b1111, 32'h20, 32'hAABBCCDD, 0, 32'h0,        0, 1);
    add(1, 4'b0100, 32'h22, 32'h000000EE, 0, 32'h0,        0, 0);
    for (int i = 0; i < 7; i++) add(0, 4'b0000, 32'h20, 32'h0, 1, 32'hAAEECCDD, 0, 0);
    add(0, 4'b0000, 32'h20, 32'h0,        1, 32'hAAEECCDD, 0, 1);
    add(1, 4'b1100, 32'h32, 32'h00001234, 0, 32'h0,        0, 1);
    add(0, 4'b0000, 32'h30, 32'h0,        1, 32'h12340000, 0, 0);
    add(1, 4'b0000, 32'h30, 32'hFFFFFFFF, 1, 32'h12340000, 0, 0);
    add(0, 4'b0000, 32'h30, 32'h0,        1, 32'h12340000, 0, 0);
    add(0, 4'b0000, 32'h30, 32'h0,        1, 32'h12340000, 0, 0);
    add(0, 4'b0000, 32'h30, 32'h0,        1, 32'h12340000, 0, 1);
    foreach (tbl[i]) begin
      step(tbl[i].we, !tbl[i].we && tbl[i].chk_rd, tbl[i].be, tbl[i].ao, tbl[i].wd,
           tbl[i].chk_rd, tbl[i].exp_rd, $sformatf("vec%0d_rdata", i));
      check($sformatf("vec%0d_stall", i), 32'(stall_seen), 32'(tbl[i].exp_stall));
      check($sformatf("vec%0d_empty", i), 32'(empty_seen), 32'(tbl[i].exp_empty));
    end

    // Back-to-back stores: the fifth lands on the first commit, the sixth stalls.
    att = 0;
    acc = 0;
    while (acc < 6 && att < 40) begin
      step(1'b1, 1'b0, 4'b1111, 32'h100 + 32'(4 * acc), 32'h50000000 + 32'(acc), 1'b0, 32'h0, "t4");
      check($sformatf("t4_stall_cyc%0d", att), 32'(stall_seen), 32'(att >= 5 && att <= 7));
      if (!stall_seen) acc++;
      att++;
    end
    check("t4_cycles", 32'(att), 32'd9);
    wait_empty(40, "t4_drain");
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'b0000, 32'h100 + 32'(4 * i), 32'h0, 1'b1, 32'h50000000 + 32'(i),
           $sformatf("t4_word%0d", i));
    end

    // Pointer wrap: 3*DEPTH distinct words with interleaved loads.
    for (int i = 0; i < 3 * DEPTH; i++) begin
      a6 = 32'h400 + 32'(4 * i) + 32'($urandom_range(0, 3));
      b6 = be_list[$urandom_range(0, 6)];
      store_hold(a6, b6, $urandom, $sformatf("t6_st%0d", i));
      load(a6, $sformatf("t6_ld_same%0d", i));
      j6 = $urandom_range(0, i);
      load(32'h400 + 32'(4 * j6), $sformatf("t6_ld_old%0d", i));
    end
    wait_empty(60, "t6_drain");
    for (int i = 0; i < 3 * DEPTH; i++) load(32'h400 + 32'(4 * i), $sformatf("t6_final%0d", i));
    check("t6_final_empty", 32'(empty_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
